serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-bit two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.
- Built around a single full-subtractor cell and a registered borrow.
- Counterpart to the adder chain; gives the arithmetic library a small-area subtract path with a start/done handshake.
- Sits beside the adder modules for datapaths where latency is cheaper than WIDTH-wide logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 2 and above.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- diff  output  WIDTH  registered result; holds the last completed result.
- borrow_out  output  1  final borrow; 1 when a < b unsigned.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; diff=0, borrow_out=0, busy=0, done=0; internal shift regs, borrow flop and counter all cleared.
- Reset mid-operation aborts immediately: partial result discarded, outputs return to reset values, no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE: when start=1 at edge k, load sa<=a, sb<=b, brw<=0, cnt<=0, go to RUN. When start=0, stay.
  - RUN: each edge computes d = sa[0]^sb[0]^brw and br' = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw).
  - RUN shifting: sa and sb shift right; d shifts into the MSB of the internal sd register; brw<=br'; cnt increments.
  - RUN exit: on the edge where cnt==WIDTH-1, i.e. edge k+WIDTH, diff<={d, sd[WIDTH-1:1]}, borrow_out<=br', go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge k, so busy=1 during cycles k+1..k+WIDTH, done=1 in cycle k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy or done is ignored, with no queueing. Operands are sampled only at acceptance, so a/b changes after acceptance have no effect.
- diff and borrow_out are not disturbed during RUN; they change only on the completion edge and then hold until the next completion or reset.
- Arithmetic is modulo 2^WIDTH. borrow_out is the unsigned borrow, not signed overflow.
- Boundary cases:
  - a==b gives diff=0, borrow_out=0.
  - b=0 gives diff=a, borrow_out=0.
  - a=0, b=1 gives diff all-ones, borrow_out=1.
- busy and done are never high together; done never asserts without a preceding accepted start.

Decomposition:
- Shared package sub_pkg: state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- Sub-module full_subtractor (purely combinational): ports d, bo, x, y, bi; d = x^y^bi, bo = (~x&y) | (~(x^y)&bi).
- full_subtractor may itself be built from two half_subtractor instances, mirroring the full_adder structure.
- serial_subtractor instantiates one full_subtractor and owns the FSM, counter and shift registers.

Test Plan:
- Reset, then start with a=100, b=37 (WIDTH=8) -> busy for 8 cycles; done in cycle 9 after acceptance; diff=63, borrow_out=0.
- a=5, b=10 -> diff=251 (8'hFB), borrow_out=1; a=0, b=1 -> diff=8'hFF, borrow_out=1; a=0, b=0 -> diff=0, borrow_out=0.
- Accept a=200, b=55; pulse start with a=1, b=1 at busy cycle 3 and in the DONE cycle -> both ignored; diff=145, exactly one done pulse.
- After a result of 63, start a=9, b=4 -> diff stays 63 throughout RUN, becomes 5 only at completion.
- Deassert rst_n asynchronously at busy cycle 4 -> busy, diff and done go to 0 immediately; a new start after release gives a correct result.
- Exhaustive sweep at WIDTH=4, all 256 a/b pairs -> diff==(a-b)&4'hF and borrow_out==(a<b), checked against a reference model.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half subtractors, mirroring the full adder.
module full_subtractor (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (.d(d1), .bo(b1), .x(x),  .y(y));
  half_subtractor u_hs1 (.d(d),  .bo(b2), .x(d1), .y(bi));

  // Both borrows can never be high together, so OR merges them.
  assign bo = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = x - y, bo set when x < y.
module half_subtractor (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock,
// with a start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] sa_q,     sa_d;
  logic [WIDTH-1:0] sb_q,     sb_d;
  logic [WIDTH-1:0] sd_q,     sd_d;
  logic             brw_q,    brw_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic bit_d;
  logic bit_bo;

  full_subtractor u_fs (
    .d  (bit_d),
    .bo (bit_bo),
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (brw_q)
  );

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can infer a latch.
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sd_d  = WIDTH'({bit_d, sd_q} >> 1);
        brw_d = bit_bo;
        cnt_d = cnt_q + CW'(1);
        // Last bit: the freshly shifted result register is the full difference.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = sd_d;
          borrow_d = bit_bo;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: shift registers, borrow and counter are cleared too, so an aborted
      // operation leaves nothing behind for the next one.
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: timeline reference model per instance (WIDTH=8 and WIDTH=4),
// per-cycle output comparison, directed cases, random ops and an exhaustive 4-bit sweep.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start8, bo8, busy8, done8;
  logic [W8-1:0] a8, b8, diff8;
  logic          start4, bo4, busy4, done4;
  logic [W4-1:0] a4, b4, diff4;

  serial_subtractor #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow_out(bo8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .diff(diff4), .borrow_out(bo4), .busy(busy4), .done(done4)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [W8-1:0] last8 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase counts cycles since acceptance (0 = idle). The result
  // is plain modular subtraction, published when the done cycle begins.
  int            ph8, ph4;
  logic [W8-1:0] m8_diff, m8_pend;
  logic          m8_bo, m8_pend_bo;
  logic [W4-1:0] m4_diff, m4_pend;
  logic          m4_bo, m4_pend_bo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph8 <= 0; m8_diff <= '0; m8_bo <= 1'b0;
    end else if (ph8 == 0) begin
      if (start8) begin
        ph8 <= 1; m8_pend <= a8 - b8; m8_pend_bo <= (a8 < b8);
      end
    end else if (ph8 == W8) begin
      ph8 <= W8 + 1; m8_diff <= m8_pend; m8_bo <= m8_pend_bo;
    end else if (ph8 == W8 + 1) begin
      ph8 <= 0;
    end else begin
      ph8 <= ph8 + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph4 <= 0; m4_diff <= '0; m4_bo <= 1'b0;
    end else if (ph4 == 0) begin
      if (start4) begin
        ph4 <= 1; m4_pend <= a4 - b4; m4_pend_bo <= (a4 < b4);
      end
    end else if (ph4 == W4) begin
      ph4 <= W4 + 1; m4_diff <= m4_pend; m4_bo <= m4_pend_bo;
    end else if (ph4 == W4 + 1) begin
      ph4 <= 0;
    end else begin
      ph4 <= ph4 + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy8", busy8, (ph8 >= 1 && ph8 <= W8));
      check("cyc_done8", done8, (ph8 == W8 + 1));
      check("cyc_diff8", diff8, m8_diff);
      check("cyc_bo8",   bo8,   m8_bo);
      check("cyc_busy4", busy4, (ph4 >= 1 && ph4 <= W4));
      check("cyc_done4", done4, (ph4 == W4 + 1));
      check("cyc_diff4", diff4, m4_diff);
      check("cyc_bo4",   bo4,   m4_bo);
    end
  end

  // One 8-bit operation; pa/pb are cycles after acceptance at which a stray
  // start (a=b=1) is pulsed. Operands are scrambled after acceptance.
  task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] b, input int pa, input int pb);
    logic [W8-1:0] ed;
    logic          eb;
    int            busy_n;
    int            done_at;
    ed = a - b;
    eb = (a < b);
    busy_n = 0;
    done_at = -1;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start8 = (n == pa || n == pb);
      a8 = start8 ? 8'd1 : 8'($urandom);
      b8 = start8 ? 8'd1 : 8'($urandom);
      if (busy8) begin
        busy_n++;
        check("hold8", diff8, last8);
      end
      if (done8) begin
        done_at = n;
        break;
      end
    end
    check("done_cycle8", done_at, W8 + 1);
    check("busy_cycles8", busy_n, W8);
    check("diff8", diff8, ed);
    check("borrow8", bo8, eb);
    @(negedge clk);
    start8 = 1'b0;
    check("done_single8", done8, 1'b0);
    check("idle_after8", busy8, 1'b0);
    last8 = ed;
  endtask

  task automatic op4(input logic [W4-1:0] a, input logic [W4-1:0] b);
    int done_at;
    done_at = -1;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) begin
        done_at = n;
        break;
      end
    end
    check("done_cycle4", done_at, W4 + 1);
    check("diff4", diff4, 32'((a - b) & 4'hF));
    check("borrow4", bo4, (a < b));
  endtask

  initial begin
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("rst_diff8", diff8, 0);
    check("rst_bo8",   bo8,   0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    op8(8'd100, 8'd37, -1, -1);
    check("lit_100_37", diff8, 8'd63);
    check("lit_100_37_bo", bo8, 1'b0);
    op8(8'd9, 8'd4, -1, -1);
    check("lit_9_4", diff8, 8'd5);
    op8(8'd5, 8'd10, -1, -1);
    check("lit_5_10", diff8, 8'hFB);
    check("lit_5_10_bo", bo8, 1'b1);
    op8(8'd0, 8'd1, -1, -1);
    check("lit_0_1", diff8, 8'hFF);
    check("lit_0_1_bo", bo8, 1'b1);
    op8(8'd0, 8'd0, -1, -1);
    check("lit_0_0", diff8, 8'h00);
    check("lit_0_0_bo", bo8, 1'b0);
    op8(8'd200, 8'd55, 3, W8 + 1);
    check("lit_200_55", diff8, 8'd145);
    repeat (3) @(negedge clk);
    check("ignored_start_busy", busy8, 1'b0);

    // Abort mid-run with an asynchronous reset at busy cycle 4.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd77; b8 = 8'd11;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", busy8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_diff", diff8, 0);
    check("abort_done", done8, 0);
    last8 = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    op8(8'd77, 8'd11, -1, -1);
    check("lit_77_11", diff8, 8'd66);

    for (int i = 0; i < 30; i++) begin
      op8(8'($urandom), 8'($urandom), -1, -1);
    end

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j));
      end
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
